dac_sample_pacer: RTL and testbench
===================================

DAC_SAMPLE_PACER -- requirements
Module: dac_sample_pacer

Interface
REQ-001 Parameter DEPTH, default 8: sample FIFO depth in entries, power of two, 2..64.
REQ-002 Parameter PRIME_LEVEL, default 2: minimum FIFO occupancy before playback starts, 1..DEPTH.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port start  input  1  one-cycle request to begin playback.
REQ-006 Port stop  input  1  one-cycle request to end playback; wins over start when both are high.
REQ-007 Port period  input  16  sample interval minus one, in clk cycles; re-sampled at every reload.
REQ-008 Port s_data  input  12  upstream sample value.
REQ-009 Port s_valid  input  1  s_data is valid.
REQ-010 Port s_ready  output  1  FIFO accepts s_data this cycle.
REQ-011 Port ch_value  output  12  registered value presented to the DAC writer.
REQ-012 Port enable  output  1  registered; DAC writer permitted to issue writes.
REQ-013 Port running  output  1  high in RUN state.
REQ-014 Port fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 Port underrun_count  output  8  ticks that found the FIFO empty, saturating.

Function
REQ-016 FIFO SHALL push when s_valid && s_ready, with s_ready = (fifo_level != DEPTH) in every state; no fall-through bypass.
REQ-017 When a push and a pop occur in the same cycle, fifo_level SHALL stay unchanged; when the FIFO is full, s_ready SHALL stay 0 even on a pop cycle.
REQ-018 The FSM SHALL have three states: IDLE, PRIME, RUN.
REQ-019 IDLE behaviour:
- enable = 0; ch_value holds its last value; the FIFO keeps filling.
- start && !stop -> PRIME on the next cycle.
REQ-020 PRIME behaviour:
- stop -> IDLE.
- Otherwise, when fifo_level >= PRIME_LEVEL: pop the head into ch_value, load the counter with period, and enter RUN; enable and running become 1 on the same edge.
REQ-021 RUN tick and counter:
- The counter SHALL decrement each cycle.
- A tick occurs when the counter is 0; on a tick the counter reloads with the current period.
- Tick spacing is period+1 cycles; period = 0 gives a tick every cycle.
REQ-022 On a RUN tick with the FIFO non-empty, the head SHALL be popped into ch_value on that edge.
REQ-023 On a RUN tick with the FIFO empty:
- ch_value SHALL hold its value.
- underrun_count SHALL increment, saturating at 255.
- enable SHALL remain 1.
REQ-024 On stop in RUN, the next state SHALL be IDLE, with enable and running 0 on the next cycle.
- No pop occurs on that edge, even if it is a tick.
- The FIFO contents and ch_value are retained.
REQ-025 A start in PRIME or RUN SHALL be ignored; underrun_count SHALL clear only on reset.
REQ-026 ch_value SHALL change only on PRIME exit or a RUN tick, so it stays stable between ticks for downstream capture at any time.

Reset
REQ-027 While rst_n = 0, asynchronously:
- state IDLE; ch_value 0; enable 0; running 0.
- fifo_level 0; underrun_count 0; counter 0; s_ready 0.
REQ-028 On the first edge after rst_n rises, s_ready SHALL be 1.
REQ-029 rst_n assertion mid-playback SHALL discard all FIFO contents with no partial pop.

Verification
REQ-030 Basic playback: push 0x100, 0x200, 0x300; period=3; start at cycle 0.
- PRIME at cycle 1.
- Cycle 2: ch_value=0x100, enable=1.
- ch_value=0x200 at cycle 6 and 0x300 at cycle 10.
REQ-031 Underrun continuation: continue REQ-030 with no further pushes.
- Ticks at cycles 14 and 18 leave ch_value=0x300.
- underrun_count becomes 1, then 2.
- enable stays 1.
REQ-032 Full FIFO: with DEPTH=8 and state IDLE, drive s_valid constantly with 10 values.
- Exactly 8 are accepted; fifo_level=8; s_ready=0.
- After start and the PRIME pop, s_ready=1 one cycle later.
REQ-033 Controls: start and stop high in the same cycle in IDLE -> remains IDLE.
- With period=0, stop in RUN on a tick cycle -> no pop, enable=0 next cycle, fifo_level unchanged.
REQ-034 Counter saturation: force 300 empty ticks with period=0 -> underrun_count=255 and holds there.
REQ-035 Mid-run reset: rst_n low during RUN with fifo_level=5.
- Immediately: ch_value=0, enable=0, fifo_level=0.
- After release, a fresh prime/run sequence reproduces REQ-030.

Source files
------------

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
//   Buffers 12-bit samples from an upstream source in a small FIFO and
//   releases them to a DAC writer at a programmable rate. Playback waits in
//   PRIME until PRIME_LEVEL samples are buffered, then pops one sample per
//   tick in RUN. A tick that finds the FIFO empty keeps the last value and
//   bumps a saturating underrun counter.
//
// Ports
//   clk            single clock
//   rst_n          asynchronous active-low reset
//   start / stop   one-cycle playback controls (stop wins)
//   period         tick interval minus one, sampled at every reload
//   s_data/s_valid/s_ready  upstream sample handshake
//   ch_value       registered sample presented to the DAC writer
//   enable         registered write permission for the DAC writer
//   running        high in RUN
//   fifo_level     current FIFO occupancy
//   underrun_count empty ticks seen, saturating at 255
module dac_sample_pacer #(
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [15:0]                period,
  input  logic [11:0]                s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [11:0]                ch_value,
  output logic                       enable,
  output logic                       running,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 underrun_count
);

  localparam int DATA_W = 12;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [15:0]         cnt;
  logic                alive;
  logic                push, pop, load, underrun;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // s_ready is held low until the first edge after reset release
  assign s_ready = alive && (fifo_level != FULL_LVL);
  assign push    = s_valid && s_ready;
  assign running = (state == RUN);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    underrun  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = PRIME;
      end
      PRIME: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (fifo_level >= PRIME_LVL) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // stop takes priority over a coincident tick: no pop on that edge
        if (stop) begin
          state_nxt = IDLE;
        end else if (cnt == 16'd0) begin
          load = 1'b1;
          if (fifo_level != '0) pop = 1'b1;
          else                  underrun = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // sample storage carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive          <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      cnt            <= '0;
      ch_value       <= '0;
      enable         <= 1'b0;
      underrun_count <= '0;
    end else begin
      alive <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (load)                           cnt <= period;
      else if (running && cnt != 16'd0)   cnt <= cnt - 16'd1;
      if (pop)      ch_value       <= mem[rd_ptr];
      if (underrun) underrun_count <= sat_inc(underrun_count);
      enable <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
module tb_dac_sample_pacer;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int S_CH  = 0;
  localparam int S_EN  = 1;
  localparam int S_RUN = 2;
  localparam int S_LVL = 3;
  localparam int S_UND = 4;
  localparam int S_RDY = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop;
  logic [15:0]   period;
  logic [11:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic [11:0]   ch_value;
  logic          enable;
  logic          running;
  logic [LW-1:0] fifo_level;
  logic [7:0]    underrun_count;

  dac_sample_pacer #(.DEPTH(DEPTH), .PRIME_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .period(period),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ch_value(ch_value), .enable(enable), .running(running),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   t0       = 0;
  bit   done     = 1'b0;

  function automatic int sig_val(input int sel);
    case (sel)
      S_CH:    return int'(ch_value);
      S_EN:    return int'(enable);
      S_RUN:   return int'(running);
      S_LVL:   return int'(fifo_level);
      S_UND:   return int'(underrun_count);
      default: return int'(s_ready);
    endcase
  endfunction

  task automatic expect_at(input int c, input int sel, input int val, input string name);
    exp_t e;
    e.at = t0 + c; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  // monitor: compares every expectation that falls due in the current cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        checks++;
        if (q[i].at < cyc || sig_val(q[i].sel) != q[i].val) begin
          failures++;
          $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", q[i].name, cyc,
                   sig_val(q[i].sel), q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < t0 + c) tick();
  endtask

  task automatic push_val(input logic [11:0] v);
    s_valid = 1'b1;
    s_data  = v;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic issue_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic issue_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    push_val(12'h100);
    push_val(12'h200);
    push_val(12'h300);
    period = 16'd3;
    t0 = cyc;
    expect_at(1,  S_RUN, 0,     {tag, "_prime_running"});
    expect_at(1,  S_EN,  0,     {tag, "_prime_enable"});
    expect_at(2,  S_CH,  'h100, {tag, "_ch_c2"});
    expect_at(2,  S_EN,  1,     {tag, "_en_c2"});
    expect_at(2,  S_LVL, 2,     {tag, "_lvl_c2"});
    expect_at(5,  S_CH,  'h100, {tag, "_ch_c5"});
    expect_at(6,  S_CH,  'h200, {tag, "_ch_c6"});
    expect_at(9,  S_CH,  'h200, {tag, "_ch_c9"});
    expect_at(10, S_CH,  'h300, {tag, "_ch_c10"});
    expect_at(10, S_LVL, 0,     {tag, "_lvl_c10"});
    expect_at(13, S_UND, 0,     {tag, "_und_c13"});
    expect_at(14, S_UND, 1,     {tag, "_und_c14"});
    expect_at(14, S_CH,  'h300, {tag, "_ch_c14"});
    expect_at(17, S_UND, 1,     {tag, "_und_c17"});
    expect_at(18, S_UND, 2,     {tag, "_und_c18"});
    expect_at(18, S_EN,  1,     {tag, "_en_c18"});
    expect_at(20, S_EN,  0,     {tag, "_stop_en"});
    expect_at(20, S_RUN, 0,     {tag, "_stop_running"});
    expect_at(20, S_CH,  'h300, {tag, "_stop_ch"});
    issue_start();
    wait_until(19);
    issue_stop();
    wait_until(21);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; period = 16'd3;
    s_data = '0; s_valid = 1'b0;

    // reset state
    t0 = 0;
    expect_at(2, S_CH,  0, "rst_ch");
    expect_at(2, S_EN,  0, "rst_en");
    expect_at(2, S_RUN, 0, "rst_running");
    expect_at(2, S_LVL, 0, "rst_lvl");
    expect_at(2, S_UND, 0, "rst_und");
    expect_at(3, S_RDY, 0, "rst_ready");
    expect_at(4, S_RDY, 1, "ready_after_release");
    wait_until(3);
    rst_n = 1'b1;
    wait_until(5);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL direct_ready_released got=%0b want=1", s_ready);
    end
    checks++;
    if (fifo_level !== '0) begin
      failures++;
      $display("FAIL direct_lvl_released got=%0d want=0", fifo_level);
    end

    // basic playback and underrun continuation
    run_basic("basic");
    checks++;
    if (underrun_count !== 8'd2) begin
      failures++;
      $display("FAIL direct_basic_und got=%0d want=2", underrun_count);
    end
    checks++;
    if (ch_value !== 12'h300) begin
      failures++;
      $display("FAIL direct_basic_ch got=0x%0h want=0x300", ch_value);
    end
    checks++;
    if (enable !== 1'b0) begin
      failures++;
      $display("FAIL direct_basic_en got=%0b want=0", enable);
    end

    // full FIFO while idle
    t0 = cyc;
    expect_at(8,  S_LVL, 8, "full_lvl8");
    expect_at(8,  S_RDY, 0, "full_ready0");
    expect_at(10, S_LVL, 8, "full_lvl_hold");
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 12'h010 + 12'(i);
      tick();
    end
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== LW'(8)) begin
      failures++;
      $display("FAIL direct_full_lvl got=%0d want=8", fifo_level);
    end
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL direct_full_ready got=%0b want=0", s_ready);
    end
    t0 = cyc;
    expect_at(1, S_RDY, 0,     "full_prime_ready0");
    expect_at(2, S_LVL, 7,     "full_pop_lvl");
    expect_at(2, S_RDY, 1,     "full_pop_ready1");
    expect_at(2, S_CH,  'h010, "full_pop_ch");
    expect_at(4, S_EN,  0,     "full_stop_en");
    expect_at(4, S_LVL, 7,     "full_stop_lvl");
    expect_at(4, S_CH,  'h010, "full_stop_ch");
    issue_start();
    wait_until(3);
    issue_stop();
    wait_until(5);

    // start and stop together in IDLE
    t0 = cyc;
    expect_at(1, S_RUN, 0, "startstop_run_c1");
    expect_at(2, S_EN,  0, "startstop_en_c2");
    expect_at(3, S_RUN, 0, "startstop_run_c3");
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    wait_until(4);

    // period 0, push+pop in one cycle, stop on a tick
    period = 16'd0;
    t0 = cyc;
    expect_at(2, S_CH,  'h011, "p0_ch_c2");
    expect_at(2, S_LVL, 6,     "p0_lvl_c2");
    expect_at(3, S_CH,  'h012, "p0_ch_c3");
    expect_at(3, S_LVL, 6,     "pushpop_lvl");
    expect_at(4, S_EN,  0,     "tickstop_en");
    expect_at(4, S_RUN, 0,     "tickstop_running");
    expect_at(4, S_CH,  'h012, "tickstop_ch");
    expect_at(4, S_LVL, 6,     "tickstop_lvl");
    issue_start();
    wait_until(2);
    push_val(12'h0AA);
    issue_stop();
    wait_until(5);

    // reset during RUN with five entries buffered
    period = 16'd3;
    t0 = cyc;
    expect_at(2, S_CH,  'h013, "mid_ch_c2");
    expect_at(2, S_LVL, 5,     "mid_lvl5");
    expect_at(2, S_RUN, 1,     "mid_running");
    expect_at(3, S_CH,  0,     "midrst_ch");
    expect_at(3, S_EN,  0,     "midrst_en");
    expect_at(3, S_LVL, 0,     "midrst_lvl");
    expect_at(3, S_RUN, 0,     "midrst_running");
    expect_at(3, S_UND, 0,     "midrst_und");
    expect_at(3, S_RDY, 0,     "midrst_ready");
    expect_at(6, S_RDY, 1,     "midrst_ready_after");
    issue_start();
    wait_until(3);
    rst_n = 1'b0;
    wait_until(5);
    rst_n = 1'b1;
    wait_until(7);
    run_basic("rerun");

    // saturation of underrun_count with period 0; start in RUN ignored
    push_val(12'h555);
    push_val(12'h666);
    period = 16'd0;
    t0 = cyc;
    expect_at(2,   S_CH,  'h555, "sat_ch_c2");
    expect_at(2,   S_LVL, 1,     "sat_lvl_c2");
    expect_at(3,   S_CH,  'h666, "sat_ch_c3");
    expect_at(4,   S_UND, 3,     "sat_und_c4");
    expect_at(51,  S_RUN, 1,     "start_in_run_running");
    expect_at(51,  S_CH,  'h666, "start_in_run_ch");
    expect_at(100, S_UND, 99,    "sat_und_c100");
    expect_at(255, S_UND, 254,   "sat_und_c255");
    expect_at(256, S_UND, 255,   "sat_und_c256");
    expect_at(303, S_UND, 255,   "sat_und_hold");
    expect_at(303, S_EN,  1,     "sat_en_hold");
    expect_at(303, S_CH,  'h666, "sat_ch_hold");
    expect_at(304, S_EN,  0,     "sat_stop_en");
    issue_start();
    wait_until(50);
    issue_start();
    wait_until(303);
    issue_stop();
    wait_until(306);

    tick();
    tick();
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        #100000;
        failures++;
        $display("FAIL timeout cyc=%0d got=running want=done", cyc);
      end
    join_any
    disable fork;
    foreach (q[i]) begin
      checks++;
      failures++;
      $display("FAIL unchecked_%s got=none want=0x%0h", q[i].name, q[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
